// File: rtl/exibe_sequencia_if.sv
// Bus between the game controller / sequence ROM and the sequence presenter.
// Start handshake: the controller raises iniciar (with limite valid in the
// same cycle); it is accepted on the first rising edge that finds the
// presenter idle (exibindo=0). Completion is a one-cycle pronto pulse, and
// exibindo drops on the following cycle.
interface exibe_sequencia_if;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_estado;

    // Controller / ROM side
    modport master (
        output iniciar, limite, dado_memoria,
        input  endereco, leds, exibindo, pronto, db_estado
    );

    // Presenter side
    modport slave (
        input  iniciar, limite, dado_memoria,
        output endereco, leds, exibindo, pronto, db_estado
    );
endinterface

// File: rtl/exibe_sequencia.sv
// Sequence presenter: walks the sequence ROM from address 0 to lim_reg,
// showing each value on the LEDs for TEMPO_ACESO cycles followed by a blank
// gap of TEMPO_APAGADO cycles, then pulses pronto.
module exibe_sequencia #(
    parameter int TEMPO_ACESO   = 1000,
    parameter int TEMPO_APAGADO = 500
) (
    input logic              clock,
    input logic              reset,
    exibe_sequencia_if.slave bus
);

    localparam int TEMPO_MAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int TW        = (TEMPO_MAX < 1) ? 1 : $clog2(TEMPO_MAX + 1);

    // Last timer value of each timed phase (timer counts 0..N-1)
    localparam logic [TW-1:0] FIM_ACESO   = TW'(TEMPO_ACESO - 1);
    localparam logic [TW-1:0] FIM_APAGADO = TW'(TEMPO_APAGADO - 1);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    estado_t       estado;
    logic [3:0]    endereco;
    logic [3:0]    lim_reg;
    logic [TW-1:0] timer;
    logic          exibindo;
    logic          pronto;

    // Sequencer: state, address, timer and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            endereco <= 4'd0;
            lim_reg  <= 4'd0;
            timer    <= '0;
            exibindo <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                INICIAL: begin
                    endereco <= 4'd0;
                    timer    <= '0;
                    if (bus.iniciar) begin
                        lim_reg  <= bus.limite;
                        exibindo <= 1'b1;
                        estado   <= CARREGA;
                    end else begin
                        exibindo <= 1'b0;
                    end
                end
                // Address already stable; this cycle lets the ROM register it
                CARREGA: begin
                    estado <= ACESO;
                end
                ACESO: begin
                    if (timer == FIM_ACESO) begin
                        timer  <= '0;
                        estado <= APAGADO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // Last-element test happens here so endereco never wraps past 15
                APAGADO: begin
                    if (timer == FIM_APAGADO) begin
                        timer <= '0;
                        if (endereco == lim_reg) begin
                            pronto <= 1'b1;
                            estado <= FIM;
                        end else begin
                            estado <= PROXIMO;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PROXIMO: begin
                    endereco <= endereco + 4'd1;
                    estado   <= CARREGA;
                end
                FIM: begin
                    endereco <= 4'd0;
                    exibindo <= 1'b0;
                    estado   <= INICIAL;
                end
                default: begin
                    endereco <= 4'd0;
                    timer    <= '0;
                    exibindo <= 1'b0;
                    estado   <= INICIAL;
                end
            endcase
        end
    end

    // LEDs follow the ROM register directly while lit, blank otherwise
    always_comb begin
        bus.leds = 4'd0;
        if (estado == ACESO) begin
            bus.leds = bus.dado_memoria;
        end
    end

    assign bus.endereco  = endereco;
    assign bus.exibindo  = exibindo;
    assign bus.pronto    = pronto;
    assign bus.db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for the sequence presenter: a small timing model predicts, per cycle,
// {db_estado, endereco, leds, exibindo, pronto}; predictions are queued and
// compared against the DUT on the falling edge.
module tb_exibe_sequencia;

    localparam int TA = 3;
    localparam int TP = 2;
    localparam int E  = 2 + TA + TP;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [13:0] exp_q[$];

    exibe_sequencia_if bus ();

    exibe_sequencia #(
        .TEMPO_ACESO  (TA),
        .TEMPO_APAGADO(TP)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence ROM contents: 1,2,4,8 repeating
    function automatic logic [3:0] rom_val(input int a);
        logic [3:0] one;
        one = 4'd1;
        return one << (a % 4);
    endfunction

    // Synchronous ROM, one cycle of read latency
    always @(posedge clk) bus.dado_memoria <= rom_val(int'(bus.endereco));

    function automatic logic [13:0] observed();
        return {bus.db_estado, bus.endereco, bus.leds, bus.exibindo, bus.pronto};
    endfunction

    // Expected outputs in cycle c of a run with last address lim (0 outside the run)
    function automatic logic [13:0] exp_word(input int c, input int lim);
        int k, r;
        logic [3:0] st, adr, led;
        logic pr;
        if (c < 1 || c > (lim + 1) * E) return 14'd0;
        k   = (c - 1) / E;
        r   = c - k * E;
        adr = 4'(k);
        led = 4'd0;
        pr  = 1'b0;
        if (r == 1) st = 4'd1;
        else if (r <= 1 + TA) begin
            st  = 4'd2;
            led = rom_val(k);
        end
        else if (r <= 1 + TA + TP) st = 4'd3;
        else if (k == lim) begin
            st = 4'd5;
            pr = 1'b1;
        end
        else st = 4'd4;
        return {st, adr, led, 1'b1, pr};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (st/adr/led/ex/pr) expected %h", tag, got, exp);
        end
    endtask

    // Queue predictions for cycles first..last, then compare each on its falling edge
    task automatic run_cycles(input int lim, input int first, input int last);
        for (int c = first; c <= last; c++) exp_q.push_back(exp_word(c, lim));
        for (int c = first; c <= last; c++) begin
            @(negedge clk);
            check_eq($sformatf("lim%0d_c%0d", lim, c), observed(), exp_q.pop_front());
        end
    endtask

    // Request a start from a falling edge; returns just after edge 0
    task automatic start_run(input int lim);
        bus.iniciar = 1'b1;
        bus.limite  = 4'(lim);
        @(posedge clk);
        #1 bus.iniciar = 1'b0;
    endtask

    task automatic idle_zero(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s_%0d", tag, i), observed(), 14'd0);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.iniciar = 1'b0;
        bus.limite  = 4'd0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.iniciar = 1'($urandom_range(0, 1));
            bus.limite  = 4'($urandom_range(0, 15));
            #1 check_eq($sformatf("in_reset_%0d", i), observed(), 14'd0);
        end
        @(negedge clk);
        bus.iniciar = 1'b0;
        rst_n       = 1'b1;
        idle_zero("idle_after_reset", 10);

        // Single element
        start_run(0);
        run_cycles(0, 1, 9);

        // Four elements
        start_run(3);
        run_cycles(3, 1, 30);

        // Full sequence
        start_run(15);
        run_cycles(15, 1, 113);

        // Ignored inputs mid-run, then iniciar held across FIM
        start_run(2);
        run_cycles(2, 1, 4);
        bus.iniciar = 1'b1;
        bus.limite  = 4'd9;
        run_cycles(2, 5, 22);
        @(posedge clk);
        #1 bus.iniciar = 1'b0;
        run_cycles(9, 1, 72);

        // Mid-run reset during ACESO of element 1
        start_run(3);
        run_cycles(3, 1, 9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_mid_aceso", observed(), 14'd0);
        idle_zero("held_reset", 3);
        rst_n = 1'b1;
        idle_zero("after_mid_reset", 4);
        start_run(3);
        run_cycles(3, 1, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
